rv_instr_encoder_loader: RTL and testbench

//  Inverse of the pipeline controller's decode: accepts symbolic instruction descriptors over a

---
 rtl/rv_instr_encoder_loader.sv | 185 ++++++++++++++++++
 tb/tb_rv_instr_encoder_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_instr_encoder_loader.sv
// rv_instr_encoder_loader
//   Boot/program loader: takes symbolic RV32I instruction descriptors over a
//   valid/ready stream, encodes each into a 32-bit word and writes it into
//   instruction memory at consecutive word addresses starting at base_addr.
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   start, base_addr           session start pulse (IDLE only) and first address
//   in_valid/in_ready          descriptor handshake (ready only while loading)
//   in_op/in_rd/in_rs1/in_rs2  symbolic op and register indices
//   in_imm, in_last            byte immediate, last-of-session marker
//   mem_we/mem_addr/mem_wdata  registered imem write port (one cycle after accept)
//   busy, done                 session active, 1-cycle end pulse
//   err_illegal, err_overflow  sticky per-session error flags
//   instr_count                words written this session
module rv_instr_encoder_loader #(
  parameter int AW    = 10,
  parameter int DEPTH = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_op,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rs1,
  input  logic [4:0]    in_rs2,
  input  logic [31:0]   in_imm,
  input  logic          in_last,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          err_illegal,
  output logic          err_overflow,
  output logic [AW:0]   instr_count
);

  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        last;
  } desc_t;

  state_t        state, state_nxt;
  desc_t         d;
  logic [AW-1:0] wptr;
  logic [31:0]   enc;
  logic          enc_ok;
  logic [2:0]    f3;
  logic [6:0]    opc;
  logic          i_ok, b_ok, j_ok, u_ok;
  logic          accept, ovf, wr;

  assign d = '{op: in_op, rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm, last: in_last};

  // Range checks: an immediate fits N signed bits when all bits above N-1 match the sign.
  assign i_ok = (&d.imm[31:11]) | ~(|d.imm[31:11]);
  assign b_ok = ((&d.imm[31:12]) | ~(|d.imm[31:12])) & ~d.imm[0];
  assign j_ok = ((&d.imm[31:20]) | ~(|d.imm[31:20])) & ~d.imm[0];
  assign u_ok = ~(|d.imm[11:0]);

  always_comb begin
    enc    = '0;
    enc_ok = 1'b0;
    f3     = 3'b000;
    opc    = 7'b0010011;
    case (d.op)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4: begin
        case (d.op)
          5'd2:    f3 = 3'b111;
          5'd3:    f3 = 3'b110;
          5'd4:    f3 = 3'b010;
          default: f3 = 3'b000;
        endcase
        enc    = {1'b0, (d.op == 5'd1), 5'b0, d.rs2, d.rs1, f3, d.rd, 7'b0110011};
        enc_ok = 1'b1;
      end
      5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10: begin
        case (d.op)
          5'd5:    begin f3 = 3'b010; opc = 7'b0000011; end
          5'd7:    f3 = 3'b100;
          5'd8:    f3 = 3'b110;
          5'd9:    f3 = 3'b010;
          5'd10:   begin f3 = 3'b000; opc = 7'b1100111; end
          default: f3 = 3'b000;
        endcase
        enc    = {d.imm[11:0], d.rs1, f3, d.rd, opc};
        enc_ok = i_ok;
      end
      5'd11: begin
        enc    = {d.imm[11:5], d.rs2, d.rs1, 3'b010, d.imm[4:0], 7'b0100011};
        enc_ok = i_ok;
      end
      5'd12: begin
        enc    = {d.imm[20], d.imm[10:1], d.imm[11], d.imm[19:12], d.rd, 7'b1101111};
        enc_ok = j_ok;
      end
      5'd13, 5'd14, 5'd15, 5'd16: begin
        case (d.op)
          5'd14:   f3 = 3'b001;
          5'd15:   f3 = 3'b100;
          5'd16:   f3 = 3'b101;
          default: f3 = 3'b000;
        endcase
        enc    = {d.imm[12], d.imm[10:5], d.rs2, d.rs1, f3, d.imm[4:1], d.imm[11], 7'b1100011};
        enc_ok = b_ok;
      end
      5'd17: begin
        enc    = {d.imm[31:12], d.rd, 7'b0110111};
        enc_ok = u_ok;
      end
      default: ;
    endcase
  end

  assign accept = in_valid & in_ready;
  // A descriptor offered once DEPTH words are in is swallowed and ends the session.
  assign ovf    = accept & (instr_count == CNT_MAX);
  assign wr     = accept & ~ovf & enc_ok;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  if (accept && (d.last || ovf)) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready = (state == S_LOAD);
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
  end

  // Write stage and per-session bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      wptr         <= '0;
      instr_count  <= '0;
      err_illegal  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      mem_we <= wr;
      if (state == S_IDLE && start) begin
        wptr         <= base_addr;
        instr_count  <= '0;
        err_illegal  <= 1'b0;
        err_overflow <= 1'b0;
      end
      if (wr) begin
        mem_addr    <= wptr;
        mem_wdata   <= enc;
        wptr        <= wptr + 1'b1;
        instr_count <= instr_count + 1'b1;
      end
      if (accept && !ovf && !enc_ok) err_illegal  <= 1'b1;
      if (ovf)                       err_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rv_instr_encoder_loader.sv
module tb_rv_instr_encoder_loader;

  localparam int AW    = 10;
  localparam int DEPTH = 4;

  logic          clk, rst_n, start, in_valid, in_last;
  logic [AW-1:0] base_addr;
  logic [4:0]    in_op, in_rd, in_rs1, in_rs2;
  logic [31:0]   in_imm;
  logic          in_ready, mem_we, busy, done, err_illegal, err_overflow;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   instr_count;

  rv_instr_encoder_loader #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .done(done), .err_illegal(err_illegal), .err_overflow(err_overflow),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_addr, m_cnt;
  bit m_eil, m_eov, ended;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference encoder: arithmetic on field values, legality from signed ranges.
  function automatic bit ref_enc(input int op, input int rd, input int rs1, input int rs2,
                                 input logic [31:0] imm, output logic [31:0] w);
    int          si;
    int unsigned u;
    int          f3;
    int          opc;
    si = int'(imm);
    u  = imm;
    w  = 32'h0;
    case (op)
      0, 1, 2, 3, 4: begin
        f3 = (op == 2) ? 7 : (op == 3) ? 6 : (op == 4) ? 2 : 0;
        w  = 32'(((op == 1) ? 32 : 0) * 2**25 + rs2 * 2**20 + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + 'h33);
        return 1'b1;
      end
      5, 6, 7, 8, 9, 10: begin
        f3  = (op == 5) ? 2 : (op == 7) ? 4 : (op == 8) ? 6 : (op == 9) ? 2 : 0;
        opc = (op == 5) ? 'h03 : (op == 10) ? 'h67 : 'h13;
        w   = 32'((u % 4096) * 2**20 + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + opc);
        return (si >= -2048 && si <= 2047);
      end
      11: begin
        w = 32'(((u / 32) % 128) * 2**25 + rs2 * 2**20 + rs1 * 2**15 + 2 * 2**12 + (u % 32) * 2**7 + 'h23);
        return (si >= -2048 && si <= 2047);
      end
      12: begin
        w = 32'(((u / 2**20) % 2) * 2**31 + ((u / 2) % 1024) * 2**21 + ((u / 2**11) % 2) * 2**20
                + ((u / 2**12) % 256) * 2**12 + rd * 2**7 + 'h6F);
        return (si >= -(2**20) && si <= 2**20 - 2 && (u % 2) == 0);
      end
      13, 14, 15, 16: begin
        f3 = (op == 14) ? 1 : (op == 15) ? 4 : (op == 16) ? 5 : 0;
        w  = 32'(((u / 2**12) % 2) * 2**31 + ((u / 32) % 64) * 2**25 + rs2 * 2**20 + rs1 * 2**15
                 + f3 * 2**12 + ((u / 2) % 16) * 2**8 + ((u / 2**11) % 2) * 2**7 + 'h63);
        return (si >= -4096 && si <= 4094 && (u % 2) == 0);
      end
      17: begin
        w = 32'((u / 4096) * 4096 + rd * 2**7 + 'h37);
        return ((u % 4096) == 0);
      end
      default: return 1'b0;
    endcase
  endfunction

  task automatic do_start(input int base);
    start = 1'b1; base_addr = AW'(base);
    @(posedge clk); #1;
    start = 1'b0;
    m_addr = base; m_cnt = 0; m_eil = 0; m_eov = 0; ended = 0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_count", 32'(instr_count), 32'd0);
    chk("start_eil", 32'(err_illegal), 32'd0);
    chk("start_eov", 32'(err_overflow), 32'd0);
  endtask

  task automatic send(input int op, input int rd, input int rs1, input int rs2,
                      input logic [31:0] imm, input bit last);
    logic [31:0] w;
    bit          legal, ovf;
    ovf   = (m_cnt == DEPTH);
    legal = ref_enc(op, rd, rs1, rs2, imm, w);
    in_op = 5'(op); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
    in_imm = imm; in_last = last; in_valid = 1'b1;
    chk("in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    if (ovf) begin
      m_eov = 1; ended = 1;
      chk("ovf_no_we", 32'(mem_we), 32'd0);
    end else if (legal) begin
      chk("we", 32'(mem_we), 32'd1);
      chk("addr", 32'(mem_addr), 32'(m_addr));
      chk("wdata", mem_wdata, w);
      m_addr = (m_addr + 1) % (2**AW);
      m_cnt++;
      if (last) ended = 1;
    end else begin
      m_eil = 1;
      chk("illegal_no_we", 32'(mem_we), 32'd0);
      if (last) ended = 1;
    end
    chk("count", 32'(instr_count), 32'(m_cnt));
    chk("eil", 32'(err_illegal), 32'(m_eil));
    chk("eov", 32'(err_overflow), 32'(m_eov));
  endtask

  task automatic finish_session();
    chk("drain_busy", 32'(busy), 32'd1);
    chk("drain_ready", 32'(in_ready), 32'd0);
    chk("drain_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd1);
    chk("done_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_count", 32'(instr_count), 32'(m_cnt));
    chk("idle_eil", 32'(err_illegal), 32'(m_eil));
    chk("idle_eov", 32'(err_overflow), 32'(m_eov));
  endtask

  function automatic logic [31:0] rand_imm(input int op);
    int r;
    r = int'($urandom_range(0, 7));
    if (r == 0) return $urandom;
    case (op)
      12:             return 32'(int'($urandom_range(0, 2200000)) - 1100000);
      13, 14, 15, 16: return 32'(int'($urandom_range(0, 8400)) - 4200);
      17:             return (r == 1) ? $urandom : ($urandom & 32'hFFFFF000);
      default:        return 32'(int'($urandom_range(0, 4200)) - 2100);
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    m_addr = 0; m_cnt = 0; m_eil = 0; m_eov = 0; ended = 0;
    #12;
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_errs", 32'({err_illegal, err_overflow}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // add x3,x1,x2 at base 0x010
    do_start('h010);
    send(0, 3, 1, 2, 32'd0, 1'b1);
    chk("add_word", mem_wdata, 32'h002081B3);
    chk("add_addr", 32'(mem_addr), 32'h010);
    finish_session();

    // addi/lw/sw at 0; a stray start while loading must not move the base
    do_start(0);
    start = 1'b1; base_addr = AW'('h155);
    @(posedge clk); #1;
    start = 1'b0;
    send(6, 1, 0, 0, 32'd5, 1'b0);
    chk("addi_word", mem_wdata, 32'h00500093);
    chk("addi_addr", 32'(mem_addr), 32'd0);
    send(5, 2, 1, 0, 32'd8, 1'b0);
    chk("lw_word", mem_wdata, 32'h0080A103);
    send(11, 0, 1, 2, 32'd4, 1'b1);
    chk("sw_word", mem_wdata, 32'h0020A223);
    chk("sw_addr", 32'(mem_addr), 32'd2);
    finish_session();

    // beq / jal / lui
    do_start('h020);
    send(13, 0, 1, 2, -32'sd4, 1'b0);
    chk("beq_word", mem_wdata, 32'hFE208EE3);
    send(12, 1, 0, 0, 32'd8, 1'b0);
    chk("jal_word", mem_wdata, 32'h008000EF);
    send(17, 5, 0, 0, 32'h12345000, 1'b1);
    chk("lui_word", mem_wdata, 32'h123452B7);
    finish_session();
    chk("lui_count", 32'(instr_count), 32'd3);

    // out-of-range immediates: nothing written, session still ends on last
    do_start(0);
    send(6, 1, 0, 0, 32'd4096, 1'b0);
    send(13, 0, 1, 2, 32'd5, 1'b1);
    finish_session();
    chk("ill_flag", 32'(err_illegal), 32'd1);
    chk("ill_count", 32'(instr_count), 32'd0);

    // DEPTH words with last on the DEPTH-th: normal end
    do_start('h100);
    for (int i = 0; i < DEPTH; i++) send(6, i + 1, 0, 0, 32'(i), i == DEPTH - 1);
    finish_session();
    chk("full_no_ovf", 32'(err_overflow), 32'd0);

    // DEPTH+1 descriptors without last: overflow
    do_start(0);
    for (int i = 0; i <= DEPTH; i++) send(0, 1, 2, 3, 32'd0, 1'b0);
    finish_session();
    chk("ovf_flag", 32'(err_overflow), 32'd1);
    chk("ovf_count", 32'(instr_count), 32'(DEPTH));

    // address wrap
    do_start(2**AW - 1);
    send(6, 1, 0, 0, 32'd1, 1'b0);
    chk("wrap_a0", 32'(mem_addr), 32'h3FF);
    send(6, 2, 0, 0, 32'd2, 1'b1);
    chk("wrap_a1", 32'(mem_addr), 32'h000);
    finish_session();

    // reset mid-stream
    do_start('h040);
    send(6, 1, 0, 0, 32'd7, 1'b0);
    chk("pre_rst_we", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_count", 32'(instr_count), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", 32'(busy), 32'd0);

    // randomized sessions
    for (int s = 0; s < 60; s++) begin
      do_start(int'($urandom_range(0, 2**AW - 1)));
      while (!ended) begin
        int op;
        if ($urandom_range(0, 4) == 0) begin
          @(posedge clk); #1;
          chk("gap_we", 32'(mem_we), 32'd0);
        end
        op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(18, 31)) : int'($urandom_range(0, 17));
        send(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 31)), rand_imm(op), $urandom_range(0, 2) == 0);
      end
      finish_session();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
